alu_crc_pipe: RTL
=================

// Module: alu_crc_pipe
// PURPOSE
//  Parametrised, handshaked successor to the 32-bit low-power ALU with CRC.
//  Accepts one operation at a time (add/sub/mul/div/chained-CRC) and computes the result.
//  Division uses an iterative restoring divider.
//  Then computes a CRC over the result and holds both until the consumer takes them.
//  Sits between the operand source and the error-checking/result sink.
// PARAMETERS
//  WIDTH     32            operand/result width (>= 8)
//  CRC_W     32            CRC register width
//  CRC_POLY  32'h04C11DB7  generator polynomial (implicit x^CRC_W term)
//  CRC_INIT  0             CRC seed for all ops except OP_CRC
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       operation offered
//  in_ready   out  1       block can accept an operation
//  A          in   WIDTH   operand A
//  B          in   WIDTH   operand B
//  opcode     in   4       0000 add, 0001 sub, 0010 mul, 0011 div, 0100 crc-chain
//  out_valid  out  1       result/crc_out/flags valid
//  out_ready  in   1       consumer takes result
//  result     out  WIDTH   arithmetic result
//  crc_out    out  CRC_W   CRC of result
//  carry      out  1       add carry-out; sub borrow (A<B); mul high half nonzero
//  err        out  1       invalid opcode or divide by zero
// BEHAVIOUR
//  Reset
//   - State IDLE.
//   - Outputs: in_ready=1, out_valid=0, result=0, crc_out=0, carry=0, err=0.
//   - The internal last_result and last_crc are cleared to 0.
//   - Reset mid-operation (any state) aborts the operation and discards it; no output is produced.
//  FSM: IDLE -> EXEC|DIV -> CRC -> OUT -> IDLE
//   - IDLE: in_ready=1. On in_valid, latch A, B and opcode, then go to EXEC.
//     Exception: div with B!=0 goes to DIV.
//   - EXEC (1 cycle): register result and flags.
//     - add/sub: result wraps mod 2^WIDTH.
//     - mul: result is the low WIDTH bits.
//     - div with B==0: result all ones, err=1.
//     - crc-chain: result=last_result.
//     - invalid opcode: result 0, err=1, carry=0.
//   - DIV: WIDTH cycles of restoring division, one quotient bit per cycle.
//     - result is the quotient; the remainder is discarded.
//     - carry=0, err=0.
//   - CRC (1 cycle): crc_out is computed over result, MSB first, no reflection, no final XOR.
//     - Seed is CRC_INIT; for crc-chain the seed is last_crc.
//     - Per-bit step: fb = crc[CRC_W-1] ^ d; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
//   - OUT: out_valid=1. result, crc_out, carry and err are held stable until out_ready=1.
//     - When out_ready=1: update last_result and last_crc, then go to IDLE.
//  Latency
//   - out_valid rises 3 cycles after the accepting edge.
//   - For div with B!=0, it rises WIDTH+3 cycles after.
//   - With out_ready tied high, the throughput is one operation per 4 cycles.
//  Boundaries and conflicts
//   - in_ready=0 in every state except IDLE. in_valid there is ignored and the operands are not sampled.
//   - out_valid and in_ready are never high together.
//   - rst has priority over every handshake event in the same cycle.
//   - A crc-chain operation issued immediately after reset uses last_result=0 and last_crc=0.
// TESTING
//  - Add: A=0x15, B=0x0A, op 0000 -> result 0x1F, carry 0, out_valid exactly 3 cycles after accept.
//  - Sub and borrow:
//    - A=0x15, B=0x0A, op 0001 -> 0x0B, carry 0.
//    - A=0x0A, B=0x15, op 0001 -> 0xFFFFFFF5, carry 1.
//  - Wrap and CRC: A=0xFFFFFFFF, B=2, op 0000 -> result 0x00000001, carry 1, crc_out 0x04C11DB7.
//    Then op 0100 -> result 0x00000001, crc_out matches bit-serial model seeded 0x04C11DB7.
//  - Mul and div:
//    - 3*4 -> 0xC.
//    - 0x10000*0x10000 -> result 0, carry 1.
//    - 16/4 -> 4, out_valid 35 cycles after accept.
//    - 16/0 -> 0xFFFFFFFF, err 1, 3-cycle latency.
//  - Backpressure: hold out_ready=0 for 10 cycles in OUT.
//    - Outputs must stay stable and in_ready must stay 0.
//    - Operands offered meanwhile must be ignored.
//  - Reset mid-div: assert rst at cycle 10 of a 16/4 div.
//    - Next cycle: IDLE, out_valid 0, all outputs 0.
//    - The following op 0100 -> result 0, crc_out 0.

Source files
------------

// File: rtl/alu_crc_pipe.sv
// Handshaked ALU (add/sub/mul/restoring div/CRC chain) that computes a CRC of each result
// and holds result, CRC and flags until the consumer accepts them.
module alu_crc_pipe #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      CRC_W    = 32,
  parameter logic [CRC_W-1:0] CRC_POLY = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] CRC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CRC_W-1:0] crc_out,
  output logic             carry,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_CRC = 4'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_DIV,
    S_CRC,
    S_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   last_result_q, last_result_d;
  logic [CRC_W-1:0]   last_crc_q, last_crc_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  // MSB-first CRC over a whole data word, no reflection, no final XOR.
  function automatic logic [CRC_W-1:0] crc_calc(input logic [CRC_W-1:0] seed,
                                                input logic [WIDTH-1:0] data);
    logic [CRC_W-1:0] c;
    c = seed;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      c = {c[CRC_W-2:0], 1'b0} ^ ({CRC_W{c[CRC_W-1] ^ data[i]}} & CRC_POLY);
    end
    return c;
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    crc_d         = crc_q;
    carry_d       = carry_q;
    err_d         = err_q;
    last_result_d = last_result_q;
    last_crc_d    = last_crc_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;

    sum    = {1'b0, a_q} + {1'b0, b_q};
    prod   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    // a_q doubles as the dividend/quotient shift register during division.
    rem_sh = {rem_q, a_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = B;
          op_d       = opcode;
          rem_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = (opcode == OP_DIV && B != '0) ? S_DIV : S_EXEC;
        end
      end
      S_DIV: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_EXEC;
      end
      S_EXEC: begin
        carry_d = 1'b0;
        err_d   = 1'b0;
        case (op_q)
          OP_ADD: {carry_d, result_d} = sum;
          OP_SUB: begin
            result_d = a_q - b_q;
            carry_d  = a_q < b_q;
          end
          OP_MUL: begin
            result_d = prod[WIDTH-1:0];
            carry_d  = |prod[2*WIDTH-1:WIDTH];
          end
          OP_DIV: begin
            if (b_q == '0) begin
              result_d = '1;
              err_d    = 1'b1;
            end else begin
              result_d = a_q;
            end
          end
          OP_CRC:  result_d = last_result_q;
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
        state_d = S_CRC;
      end
      S_CRC: begin
        crc_d       = crc_calc((op_q == OP_CRC) ? last_crc_q : CRC_INIT, result_q);
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          last_result_d = result_q;
          last_crc_d    = crc_q;
          out_valid_d   = 1'b0;
          in_ready_d    = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the values from
  // before the edge; blocking would let later lines see already-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      result_q      <= '0;
      crc_q         <= '0;
      carry_q       <= 1'b0;
      err_q         <= 1'b0;
      last_result_q <= '0;
      last_crc_q    <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      crc_q         <= crc_d;
      carry_q       <= carry_d;
      err_q         <= err_d;
      last_result_q <= last_result_d;
      last_crc_q    <= last_crc_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // NOTE: operand and divider registers are left out of reset; they are
  // always loaded on accept before anything reads them.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    op_q  <= op_d;
    rem_q <= rem_d;
    cnt_q <= cnt_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign crc_out   = crc_q;
  assign carry     = carry_q;
  assign err       = err_q;

endmodule
